// File: rtl/policy_gen.sv
// -----------------------------------------------------------------------------
// policy_gen
//
// Epsilon-greedy action selector that feeds the game control unit. For each
// accepted request it returns one board cell index (0..8) that is empty in
// the board snapshot taken on the accept edge. It can also return 4'hF when
// no legal move exists.
//
// On an accepted request exactly one of three paths runs:
//   - no empty cell        : answer 4'hF straight away
//   - explore (random)     : walk from a pseudo-random start cell to the first
//                            empty cell, with wrap-around
//   - exploit (greedy)     : stream Q(0)..Q(8) from the external Q memory and
//                            keep the largest signed value among empty cells
//
// Ports
//   clock         in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   soft_clear    in   synchronous abort of any in-flight request (no pulse)
//   start         in   request one action, honoured only while idle
//   board[17:0]   in   board snapshot, cell k at [2k+1:2k], 00 = empty
//   epsilon[7:0]  in   exploration threshold, compared against lfsr[7:0]
//   q_rd_en       out  Q memory read strobe
//   q_addr[3:0]   out  cell index being read
//   q_data[QW-1:0] in  signed Q-value, valid one cycle after q_rd_en
//   action[3:0]   out  chosen cell, or 4'hF for no legal move
//   action_valid  out  one-cycle pulse qualifying action/explored
//   explored      out  1 = action came from the exploration path
//   busy          out  high whenever not idle
// -----------------------------------------------------------------------------
module policy_gen #(
    parameter int          QW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          soft_clear,
    input  logic          start,
    input  logic [17:0]   board,
    input  logic [7:0]    epsilon,
    output logic          q_rd_en,
    output logic [3:0]    q_addr,
    input  logic [QW-1:0] q_data,
    output logic [3:0]    action,
    output logic          action_valid,
    output logic          explored,
    output logic          busy
);

    // An all-zero LFSR state would lock up, so a zero seed falls back to ACE1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [3:0]  LAST_CELL = 4'd8;
    localparam logic [3:0]  NO_MOVE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_EXPLORE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:0]          lfsr_q, lfsr_d;
    logic [17:0]          brd_q, brd_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [3:0]           best_idx_q, best_idx_d;
    logic signed [QW-1:0] best_q, best_d;
    logic                 best_valid_q, best_valid_d;
    logic                 q_rd_en_q, q_rd_en_d;
    logic [3:0]           q_addr_q, q_addr_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [3:0]           pend_idx_q, pend_idx_d;
    logic [3:0]           action_q, action_d;
    logic                 explored_q, explored_d;

    // -------------------------------------------------------------------------
    // Per-cell emptiness of the live board (used on accept) and of the latched
    // snapshot (used by the scan and explore paths).
    // -------------------------------------------------------------------------
    logic [8:0] board_empty;
    logic [8:0] brd_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign board_empty[gi] = (board[2*gi+1:2*gi] == 2'b00);
            assign brd_empty[gi]   = (brd_q[2*gi+1:2*gi] == 2'b00);
        end
    endgenerate

    logic       any_empty;
    logic       go_explore;
    logic [3:0] ptr_init;
    logic       cand_take;
    logic       scan_last;

    assign any_empty  = |board_empty;
    assign go_explore = (lfsr_q[7:0] < epsilon);
    // lfsr[11:8] spans 0..15; one conditional subtract folds it onto 0..8.
    assign ptr_init   = (lfsr_q[11:8] >= 4'd9) ? (lfsr_q[11:8] - 4'd9) : lfsr_q[11:8];

    // The data returned this cycle belongs to the address issued last cycle
    // (pend_idx_q). A strict compare makes a tie keep the earlier,
    // lower-index cell.
    assign cand_take = rd_pend_q && brd_empty[pend_idx_q] &&
                       (!best_valid_q || ($signed(q_data) > best_q));
    assign scan_last = rd_pend_q && (pend_idx_q == LAST_CELL);

    // -------------------------------------------------------------------------
    // LFSR: Fibonacci, x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
    // It runs freely in every state and is unaffected by soft_clear.
    // -------------------------------------------------------------------------
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (soft_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!any_empty) begin
                            state_d = S_DONE;
                        end else if (go_explore) begin
                            state_d = S_EXPLORE;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_last) begin
                        state_d = S_DONE;
                    end
                end
                S_EXPLORE: begin
                    if (brd_empty[ptr_q]) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        brd_d        = brd_q;
        ptr_d        = ptr_q;
        best_idx_d   = best_idx_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        q_rd_en_d    = 1'b0;
        q_addr_d     = q_addr_q;
        rd_pend_d    = 1'b0;
        pend_idx_d   = pend_idx_q;
        action_d     = action_q;
        explored_d   = explored_q;

        if (!soft_clear) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        brd_d        = board;
                        ptr_d        = ptr_init;
                        best_valid_d = 1'b0;
                        if (!any_empty) begin
                            action_d   = NO_MOVE;
                            explored_d = 1'b0;
                        end else if (!go_explore) begin
                            // First read is issued in the cycle right after accept.
                            q_rd_en_d = 1'b1;
                            q_addr_d  = 4'd0;
                        end
                    end
                end
                S_SCAN: begin
                    // Two-stage pipeline: the issue side walks q_addr 0..8,
                    // the compare side follows one cycle behind.
                    rd_pend_d  = q_rd_en_q;
                    pend_idx_d = q_addr_q;
                    if (q_rd_en_q && (q_addr_q != LAST_CELL)) begin
                        q_rd_en_d = 1'b1;
                        q_addr_d  = q_addr_q + 4'd1;
                    end
                    if (cand_take) begin
                        best_idx_d   = pend_idx_q;
                        best_d       = $signed(q_data);
                        best_valid_d = 1'b1;
                    end
                    if (scan_last) begin
                        // Fold in the final compare in the same cycle.
                        action_d   = cand_take ? pend_idx_q : best_idx_q;
                        explored_d = 1'b0;
                    end
                end
                S_EXPLORE: begin
                    if (brd_empty[ptr_q]) begin
                        action_d   = ptr_q;
                        explored_d = 1'b1;
                    end else begin
                        ptr_d = (ptr_q == LAST_CELL) ? 4'd0 : (ptr_q + 4'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q       <= SEED_EFF;
            brd_q        <= '0;
            ptr_q        <= '0;
            best_idx_q   <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            q_rd_en_q    <= 1'b0;
            q_addr_q     <= '0;
            rd_pend_q    <= 1'b0;
            pend_idx_q   <= '0;
            action_q     <= '0;
            explored_q   <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            brd_q        <= brd_d;
            ptr_q        <= ptr_d;
            best_idx_q   <= best_idx_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            q_rd_en_q    <= q_rd_en_d;
            q_addr_q     <= q_addr_d;
            rd_pend_q    <= rd_pend_d;
            pend_idx_q   <= pend_idx_d;
            action_q     <= action_d;
            explored_q   <= explored_d;
        end
    end

    assign q_rd_en      = q_rd_en_q;
    assign q_addr       = q_addr_q;
    assign action       = action_q;
    assign explored     = explored_q;
    assign action_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/policy_gen.md
Name: policy_gen

Overview:
- Action-selection stage directly upstream of the game control unit. Produces the 4-bit cell index (0..8) that the control unit writes into its board as the agent's move.
- Runs an epsilon-greedy policy: on each request it either explores by picking a pseudo-random empty cell, or exploits by scanning per-cell Q-values from an external Q memory and returning the best empty cell.
- Board encoding per cell, 2 bits, cell k at board[2k+1:2k]: 00 empty, 01 agent, 10 player, 11 treated as occupied.

Parameters:
- QW, 16, Q-value width, signed two's complement.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_clear  in  1  synchronous abort; driven by the control unit's rst_policygen.
- start  in  1  request one action; accepted only in IDLE.
- board  in  18  board snapshot, sampled on accept.
- epsilon  in  8  exploration threshold, sampled on accept; 0 = never explore, 255 = explore unless lfsr[7:0]==255.
- q_rd_en  out  1  Q memory read strobe.
- q_addr  out  4  cell index being read (0..8).
- q_data  in  QW  Q-value, valid exactly 1 cycle after q_rd_en.
- action  out  4  chosen cell 0..8, or 4'hF = no legal move.
- action_valid  out  1  one-cycle pulse qualifying action.
- explored  out  1  qualified by action_valid: 1 = exploration path.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE; action=0, action_valid=0, explored=0, q_rd_en=0, q_addr=0, busy=0; LFSR=SEED.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle regardless of state. soft_clear does not touch it.
- States: IDLE, SCAN, EXPLORE, DONE.
- IDLE, start=1: latch board into brd_r and epsilon into eps_r.
  - If no cell is 00: go to DONE with action=4'hF, explored=0.
  - Else if lfsr[7:0] < epsilon: go to EXPLORE. Pointer p = lfsr[11:8], minus 9 if >=9.
  - Else: go to SCAN with idx=0, best_valid=0.
- start while busy is ignored; there is no queueing.
- SCAN:
  - Cycles 1..9 after accept: q_rd_en=1, q_addr=idx, idx 0..8.
  - Data for idx arrives next cycle. Compare only if brd_r cell idx is empty.
  - Candidate replaces the best when best_valid=0 or q_data > best_q (signed, strict). Ties therefore keep the lowest index.
  - After the data for idx 8 is captured (cycle 10), go to DONE.
  - q_rd_en=0 outside SCAN issue cycles; q_addr holds its last value.
- EXPLORE:
  - Each cycle, if brd_r cell p is empty: action=p, go to DONE.
  - Otherwise p increments, wrapping 8→0.
  - Terminates within 9 cycles, guaranteed because at least one cell is empty.
  - Never reads Q memory.
- DONE: action_valid=1 for exactly one cycle with action/explored stable; next cycle IDLE.
  - action and explored hold until the next DONE.
- Latency from the accept edge:
  - Greedy: action_valid on cycle 11.
  - Explore: cycles 2..10.
  - No-move: cycle 1.
- soft_clear=1 (synchronous):
  - State goes to IDLE and action_valid=0; any in-flight scan/explore is discarded with no pulse.
  - action retains its value.
  - Has priority over start in the same cycle.
- Returned action is always an empty cell of the sampled board, or 4'hF.
- board/epsilon changes after accept have no effect.
- rst_n asserted mid-operation: immediate return to reset values.

Test Plan:
- Empty board, epsilon=0, Q[k]=k*10 → greedy: q_addr walks 0..8; action=8, explored=0, action_valid on cycle 11.
- board=18'h00015 (cells 0,1,2 agent), epsilon=0, all Q equal (=5) → action=3 (lowest-index tie among empty cells).
- Board with cell 4 the only empty cell, epsilon=255, lfsr sampled with [7:0]≠255 → explored=1, action=4, no q_rd_en, pulse within 10 cycles.
- Full board (draw pattern), start → action=4'hF, action_valid on cycle 1, explored=0.
- Signed compare: Q[0]=-3, Q[1]=16'h8000, Q[2..8]=-5 on empty board, epsilon=0 → action=0.
- soft_clear asserted on cycle 5 of a scan, with start held high in the same cycle → no action_valid, busy=0 next cycle, start is not accepted that cycle; a new start afterward completes normally.
